// File: rtl/tristate_bus_pkg.sv
// Shared types and constants for the tristate bus arbiter: requester count,
// select width, FSM state encoding and the default maximum tenure.
package tristate_bus_pkg;

  localparam int NUM_REQ         = 4;
  localparam int SEL_W           = 2;
  localparam int MAX_TENURE_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting one past the
// previous owner and wrapping around the requester ring.
module rr_pick
  import tristate_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_owner,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_owner + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter driving a 4:1 tristate bus with a guaranteed dead
// cycle between owners. Optional tenure timeout: TRISTATE_BUS_ARB_TIMEOUT_EN.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int MAX_TENURE = MAX_TENURE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_en,
  output logic               busy,
  output logic               timeout
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               bus_en_q, bus_en_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   winner;
  logic               any_req;

  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
  logic [7:0] ten_q, ten_d;
  logic       timeout_q, timeout_d;
  logic       others_req;

  assign others_req = |(req & ~onehot(sel_q));
`else
  logic [7:0] unused_tenure;
  assign unused_tenure = 8'(MAX_TENURE);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
    ten_d     = ten_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE, TURNAROUND: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = winner;
          last_d  = winner;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = TURNAROUND;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
        end else if (ten_q == 8'(MAX_TENURE - 1) && others_req) begin
          state_d   = TURNAROUND;
          timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
    // Counter saturates at MAX_TENURE-1 so a lone owner is never released.
    if (state_d == GRANT) begin
      if (state_q != GRANT)                    ten_d = '0;
      else if (ten_q != 8'(MAX_TENURE - 1))    ten_d = ten_q + 8'd1;
    end
`endif

    // Outputs are registered, so they are derived from the next state.
    grant_d  = (state_d == GRANT) ? onehot(sel_d) : '0;
    bus_en_d = (state_d == GRANT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= '1;
      grant_q  <= '0;
      bus_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      bus_en_q <= bus_en_d;
      busy_q   <= busy_d;
    end
  end

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      ten_q     <= ten_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant  = grant_q;
  assign sel    = sel_q;
  assign bus_en = bus_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with per-cycle bus invariants.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       bus_en;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.MAX_TENURE(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .bus_en  (bus_en),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_owner(input string tag, input int k);
    chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << k));
    chk({tag, "_sel"},   32'(sel),   32'(k));
    chk({tag, "_en"},    32'(bus_en), 32'd1);
  endtask

  // Bus invariants sampled every cycle on the falling edge
  logic       prev_en;
  logic [1:0] prev_sel;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("inv_en_eq_grant", 32'(bus_en), 32'(|grant));
      if (prev_en && bus_en) chk("inv_sel_stable", 32'(sel), 32'(prev_sel));
      prev_en  = bus_en;
      prev_sel = sel;
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_en", 32'(bus_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Single request after reset: requester 0 has first priority
    req = 4'b0001;
    step();
    chk_owner("first", 0);
    chk("first_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    chk("ta_en", 32'(bus_en), 32'd0);
    chk("ta_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sel_hold", 32'(sel), 32'd0);

    // All requesting, each owner drops for one cycle after two GRANT cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_owner("rr_g1", k);
      step();
      chk_owner("rr_g2", k);
      req = 4'b1111 & ~(4'b0001 << k);
      step();
      chk("rr_dead_en", 32'(bus_en), 32'd0);
      chk("rr_dead_grant", 32'(grant), 32'd0);
      req = 4'b1111;
    end
    step();
    chk_owner("rr_wrap", 0);
    req = 4'b0000;
    step();
    step();

    // Owner 2 keeps the bus while requester 0 waits
    do_reset();
    req = 4'b0100;
    step();
    chk_owner("hold_start", 2);
    req = 4'b0101;
    step();
    chk_owner("hold_a", 2);
    step();
    chk_owner("hold_b", 2);
    req = 4'b0001;
    step();
    chk("hold_ta_en", 32'(bus_en), 32'd0);
    step();
    chk_owner("hold_next", 0);
    req = 4'b0000;
    step();
    step();

    // Tenure behaviour with two requesters held
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 10; c++) begin
      step();
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
      if (c <= 4) begin
        chk_owner("tmo_own0", 0);
        chk("tmo_pulse0", 32'(timeout), 32'd0);
      end else if (c == 5 || c == 10) begin
        chk("tmo_dead_en", 32'(bus_en), 32'd0);
        chk("tmo_pulse", 32'(timeout), 32'd1);
      end else begin
        chk_owner("tmo_own1", 1);
        chk("tmo_pulse1", 32'(timeout), 32'd0);
      end
`else
      chk_owner("notmo_own0", 0);
      chk("notmo_pulse", 32'(timeout), 32'd0);
`endif
    end
    req = 4'b0000;
    step();
    step();

    // Asynchronous reset in the middle of owner 3's tenure
    do_reset();
    req = 4'b1000;
    step();
    chk_owner("r3_start", 3);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_en", 32'(bus_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tmo", 32'(timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk_owner("post_rst", 3);
    req = 4'b0000;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
